// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight to a
// variable-latency instruction memory, buffers returned words in a small
// prefetch FIFO and hands them to the datapath over a valid/ready handshake.
// A redirect flushes the FIFO and discards any response still in flight.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  // Address of the request being drained; fetch_pc may move on under it.
  logic [ADDR_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [31:0]           fifo_instr_q [DEPTH];
  logic [31:0]           fifo_instr_d [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_d [DEPTH];

  logic                  push;
  logic                  pop;
  logic [CntW-1:0]       count_after;
  logic [ADDR_WIDTH-1:0] redirect_tgt;
  logic                  unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Head of FIFO drives the datapath; outputs read as zero when empty.
  always_comb begin
    instr_valid = (count_q != '0);
    instr       = '0;
    instr_pc    = '0;
    if (instr_valid) begin
      instr    = fifo_instr_q[rd_ptr_q];
      instr_pc = fifo_pc_q[rd_ptr_q];
    end
  end

  // Handshake qualifiers and the FIFO occupancy after this cycle's push/pop.
  always_comb begin
    push        = (state_q == StReq) && imem_ack && !redirect_valid;
    pop         = instr_valid && instr_ready && !redirect_valid;
    count_after = count_q;
    if (push && !pop) begin
      count_after = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_after = count_q - CntW'(1);
    end
  end

  // Fetch FSM: next state, PC update and memory request outputs.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    imem_req     = 1'b0;
    imem_addr    = fetch_pc_q;
    case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
          state_d    = StReq;
        end else if (count_q < DepthCnt) begin
          state_d = StReq;
        end
      end
      StReq: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
          if (!imem_ack) begin
            // Request still in flight: hold its address until it is acked.
            drain_addr_d = fetch_pc_q;
            state_d      = StDrain;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          if (count_after >= DepthCnt) begin
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
        end
        if (imem_ack) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Prefetch FIFO next state: flush on redirect, otherwise push/pop.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
        wr_ptr_d               = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_after;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fifo_instr_q <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default instance driven by a programmable
// latency memory, plus a RESET_PC=0xF8 instance on a zero-wait memory.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;

  logic        req_w;
  logic [7:0]  addr_w;
  logic        ack_w;
  logic [31:0] rdata_w;
  logic        redirect_w;
  logic [7:0]  rpc_w;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [7:0]  pc_w;
  logic        ready_w;

  int n_cmp;
  int n_bad;
  int mem_lat;
  int wait_cnt;

  fetch_unit #(.ADDR_WIDTH(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  fetch_unit #(.ADDR_WIDTH(8), .DEPTH(4), .RESET_PC(8'hF8)) dut_w (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (req_w),
    .imem_addr      (addr_w),
    .imem_ack       (ack_w),
    .imem_rdata     (rdata_w),
    .redirect_valid (redirect_w),
    .redirect_pc    (rpc_w),
    .instr_valid    (valid_w),
    .instr          (instr_w),
    .instr_pc       (pc_w),
    .instr_ready    (ready_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [7:0] a);
    return {24'hC0DE5A, a};
  endfunction

  // Memory models: ack after mem_lat wait cycles; dut_w always zero-wait.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    ack_w      = 1'b0;
    rdata_w    = '0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wait_cnt == mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = data_of(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
      ack_w   = req_w;
      rdata_w = data_of(addr_w);
    end
  end

  // Advance one cycle; observe just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = rdy;
    mem_lat        = lat;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_cmp++; if (instr_pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h want 00", instr_pc); end
    n_cmp++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
    n_cmp++; if (addr_w !== 8'hF8) begin n_bad++; $display("FAIL reset_addr_w: got %h want f8", addr_w); end
    do_reset(0, 1'b1);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b want 0", imem_req); end
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL first_req: got %b want 1", imem_req); end
  endtask

  task automatic test_stream();
    logic [7:0] ea;
    logic [7:0] ep;
    do_reset(0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      ea = 8'(4 * k);
      ep = 8'(4 * (k - 1));
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== ea) begin n_bad++; $display("FAIL stream_addr k=%0d: got req=%b addr=%h want 1/%h", k, imem_req, imem_addr, ea); end
      n_cmp++; if (instr_valid !== (k >= 1)) begin n_bad++; $display("FAIL stream_valid k=%0d: got %b want %b", k, instr_valid, (k >= 1)); end
      if (k >= 1) begin
        n_cmp++; if (instr_pc !== ep || instr !== data_of(ep)) begin n_bad++; $display("FAIL stream_head k=%0d: got %h/%h want %h/%h", k, instr_pc, instr, ep, data_of(ep)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ep;
    do_reset(0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'(4 * k)) begin n_bad++; $display("FAIL bp_fill k=%0d: got req=%b addr=%h want 1/%h", k, imem_req, imem_addr, 8'(4 * k)); end
    end
    for (int k = 4; k < 7; k++) begin
      step();
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_full_req k=%0d: got %b want 0", k, imem_req); end
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin n_bad++; $display("FAIL bp_full_head k=%0d: got %b/%h want 1/00", k, instr_valid, instr_pc); end
    end
    instr_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      ep = 8'(4 * j);
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== ep || instr !== data_of(ep)) begin n_bad++; $display("FAIL bp_resume_head j=%0d: got %b/%h/%h want 1/%h", j, instr_valid, instr_pc, instr, ep); end
      if (j == 1) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_resume_idle: got %b want 0", imem_req); end
      end else begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'(8'h10 + 4 * (j - 2))) begin n_bad++; $display("FAIL bp_resume_addr j=%0d: got %b/%h want 1/%h", j, imem_req, imem_addr, 8'(8'h10 + 4 * (j - 2))); end
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] ea;
    logic       ev;
    do_reset(3, 1'b1);
    for (int k = 0; k < 12; k++) begin
      step();
      ea = 8'(4 * (k / 4));
      ev = (k >= 4) && (k % 4 == 0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== ea) begin n_bad++; $display("FAIL lat_addr k=%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, ea); end
      n_cmp++; if (instr_valid !== ev) begin n_bad++; $display("FAIL lat_valid k=%0d: got %b want %b", k, instr_valid, ev); end
      if (ev) begin
        n_cmp++; if (instr_pc !== 8'(4 * (k / 4 - 1))) begin n_bad++; $display("FAIL lat_pc k=%0d: got %h want %h", k, instr_pc, 8'(4 * (k / 4 - 1))); end
      end
    end
  endtask

  task automatic test_drain_redirect();
    logic [7:0] ea;
    do_reset(2, 1'b1);
    step();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || imem_ack !== 1'b0) begin n_bad++; $display("FAIL drain_c0: got %b/%h/%b want 1/00/0", imem_req, imem_addr, imem_ack); end
    redirect_valid = 1'b1;
    redirect_pc    = 8'h43;
    for (int k = 1; k <= 6; k++) begin
      step();
      redirect_valid = 1'b0;
      ea = (k <= 2) ? 8'h00 : ((k <= 5) ? 8'h40 : 8'h44);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== ea) begin n_bad++; $display("FAIL drain_addr k=%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, ea); end
      n_cmp++; if (instr_valid !== (k == 6)) begin n_bad++; $display("FAIL drain_valid k=%0d: got %b want %b", k, instr_valid, (k == 6)); end
    end
    n_cmp++; if (instr_pc !== 8'h40 || instr !== data_of(8'h40)) begin n_bad++; $display("FAIL drain_head: got %h/%h want 40/%h", instr_pc, instr, data_of(8'h40)); end
  endtask

  task automatic test_redirect_ack();
    do_reset(0, 1'b1);
    repeat (3) step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h04 || imem_ack !== 1'b1) begin n_bad++; $display("FAIL rack_pre: got %b/%h/%b want 1/04/1", instr_valid, instr_pc, imem_ack); end
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h80) begin n_bad++; $display("FAIL rack_addr: got %b/%h want 1/80", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rack_flush: got %b want 0", instr_valid); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h80 || imem_addr !== 8'h84) begin n_bad++; $display("FAIL rack_next: got %b/%h/%h want 1/80/84", instr_valid, instr_pc, imem_addr); end
    step();
    n_cmp++; if (instr_pc !== 8'h84) begin n_bad++; $display("FAIL rack_next2: got %h want 84", instr_pc); end
  endtask

  task automatic test_idle_redirect();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    mem_lat        = 0;
    repeat (2) @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h22;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_redir_req0: got %b want 0", imem_req); end
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h20) begin n_bad++; $display("FAIL idle_redir_addr: got %b/%h want 1/20", imem_req, imem_addr); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h20 || imem_addr !== 8'h24) begin n_bad++; $display("FAIL idle_redir_head: got %b/%h/%h want 1/20/24", instr_valid, instr_pc, imem_addr); end
  endtask

  task automatic test_wrap_async_reset();
    logic [7:0] ea;
    logic [7:0] ep;
    do_reset(0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      ea = 8'(8'hF8 + 4 * k);
      ep = 8'(8'hF8 + 4 * (k - 1));
      n_cmp++; if (req_w !== 1'b1 || addr_w !== ea) begin n_bad++; $display("FAIL wrap_addr k=%0d: got %b/%h want 1/%h", k, req_w, addr_w, ea); end
      if (k >= 1) begin
        n_cmp++; if (valid_w !== 1'b1 || pc_w !== ep || instr_w !== data_of(ep)) begin n_bad++; $display("FAIL wrap_head k=%0d: got %b/%h/%h want 1/%h", k, valid_w, pc_w, instr_w, ep); end
      end
    end
    // Assert reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (req_w !== 1'b0 || valid_w !== 1'b0 || instr_w !== 32'h0) begin n_bad++; $display("FAIL async_w: got %b/%b/%h want 0/0/0", req_w, valid_w, instr_w); end
    n_cmp++; if (addr_w !== 8'hF8) begin n_bad++; $display("FAIL async_addr_w: got %h want f8", addr_w); end
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL async_main: got %b/%b want 0/0", imem_req, instr_valid); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    mem_lat        = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    redirect_w     = 1'b0;
    rpc_w          = '0;
    ready_w        = 1'b1;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_drain_redirect();
    test_redirect_ack();
    test_idle_redirect();
    test_wrap_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
